// File: rtl/wb_reg_file.sv
// Write-back stage: selects the result, commits it to a 32x32 register file,
// and serves two bypassed combinational read ports plus a retired-write counter.
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reg_writeW,
    input  logic              i_mem_to_regW,
    input  logic [DATA_W-1:0] i_alu_outW,
    input  logic [DATA_W-1:0] i_dm_outW,
    input  logic [ADDR_W-1:0] i_write_regW,
    input  logic [ADDR_W-1:0] i_ra1D,
    input  logic [ADDR_W-1:0] i_ra2D,
    output logic [DATA_W-1:0] o_rd1D,
    output logic [DATA_W-1:0] o_rd2D,
    output logic [DATA_W-1:0] o_resultW,
    output logic [CNT_W-1:0]  o_wb_count
);

    localparam int NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NumRegs];
    logic [CNT_W-1:0]  wbCount;
    logic              writeEn;

    always_comb begin
        o_resultW = i_mem_to_regW ? i_dm_outW : i_alu_outW;
        writeEn   = i_reg_writeW && (i_write_regW != '0);
    end

    // Reset wins over a concurrent write; $0 is cleared by reset and never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs    <= '{default: '0};
            wbCount <= '0;
        end else if (writeEn) begin
            regs[i_write_regW] <= o_resultW;
            wbCount            <= wbCount + CNT_W'(1);
        end
    end

    always_comb begin
        o_rd1D = '0;
        if (i_ra1D != '0) begin
            if (writeEn && (i_write_regW == i_ra1D))
                o_rd1D = o_resultW;
            else
                o_rd1D = regs[i_ra1D];
        end
    end

    always_comb begin
        o_rd2D = '0;
        if (i_ra2D != '0) begin
            if (writeEn && (i_write_regW == i_ra2D))
                o_rd2D = o_resultW;
            else
                o_rd2D = regs[i_ra2D];
        end
    end

    assign o_wb_count = wbCount;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed cases followed by random
// traffic, all compared against an array-based model of the register file.
module tb_wb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite;
    logic        memToReg;
    logic [31:0] aluOut;
    logic [31:0] dmOut;
    logic [4:0]  writeReg;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] resultW;
    logic [31:0] wbCount;

    logic [31:0] model [32];
    logic [31:0] modelCount;
    int          testCount = 0;
    int          failCount = 0;

    always #5 clk = ~clk;

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_reg_writeW (regWrite),
        .i_mem_to_regW(memToReg),
        .i_alu_outW   (aluOut),
        .i_dm_outW    (dmOut),
        .i_write_regW (writeReg),
        .i_ra1D       (ra1),
        .i_ra2D       (ra2),
        .o_rd1D       (rd1),
        .o_rd2D       (rd2),
        .o_resultW    (resultW),
        .o_wb_count   (wbCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // What decode should see: $0 is zero, a pending real write is visible at once.
    function automatic logic [31:0] expRead(input logic [4:0] addr, input bit we,
                                            input logic [4:0] wr, input logic [31:0] res);
        if (addr == 0) return 32'h0;
        if (we && wr != 0 && wr == addr) return res;
        return model[addr];
    endfunction

    task automatic cyc(input bit r, input bit we, input bit m2r,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] res;
        rst = r; regWrite = we; memToReg = m2r;
        aluOut = alu; dmOut = dm; writeReg = wr; ra1 = a1; ra2 = a2;
        #2;
        res = m2r ? dm : alu;
        checkVal("result", resultW, res);
        checkVal("rd1", rd1, expRead(a1, we, wr, res));
        checkVal("rd2", rd2, expRead(a2, we, wr, res));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            modelCount = 32'h0;
        end else if (we && wr != 0) begin
            model[wr]  = res;
            modelCount = modelCount + 32'd1;
        end
        #1;
        checkVal("count", wbCount, modelCount);
    endtask

    task automatic readAll();
        for (int i = 0; i < 32; i += 2)
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(i + 1));
    endtask

    initial begin
        rst = 1'b1; regWrite = 1'b0; memToReg = 1'b0;
        aluOut = '0; dmOut = '0; writeReg = '0; ra1 = '0; ra2 = '0;
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        modelCount = 32'h0;
        #1;

        readAll();
        checkVal("reset_count", wbCount, 32'h0);

        cyc(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h5555_5555, 5'd8, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h7777_7777, 32'hDEAD_BEEF, 5'd9, 5'd8, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd9);
        checkVal("reg8", rd1, 32'h0000_1234);
        checkVal("two_writes", wbCount, 32'd2);

        cyc(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd5, 5'd5, 5'd5);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        checkVal("reg5_after", rd1, 32'hCAFE_F00D);

        cyc(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd5);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        checkVal("zero_reg", rd1, 32'h0);
        checkVal("zero_nocount", wbCount, 32'd3);

        cyc(1'b0, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 5'd3, 5'd3, 5'd3);
        checkVal("nowrite_count", wbCount, 32'd3);

        for (int i = 1; i < 32; i++)
            cyc(1'b0, 1'b1, 1'b0, 32'(i), 32'h0, 5'(i), 5'(i - 1), 5'(i));
        cyc(1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0, 5'd7, 5'd7, 5'd31);
        checkVal("rst_count", wbCount, 32'h0);
        readAll();
        cyc(1'b0, 1'b1, 1'b1, 32'h0, 32'h1357_9BDF, 5'd7, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd6);
        checkVal("post_rst_write", rd1, 32'h1357_9BDF);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr, a1, a2;
            wr = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom, $urandom, wr, a1, a2);
        end
        readAll();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
